// File: rtl/sample_framer_if.sv
// Sample-word handshake and framed serial output bundle for sample_framer.
interface sample_framer_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic              tx_bit;
   logic              tx_frame;
   logic              tx_sof;
   logic              underrun;
   logic [15:0]       frame_count;

   modport master (
      output in_data, in_valid,
      input  in_ready, tx_bit, tx_frame, tx_sof, underrun, frame_count
   );

   modport slave (
      input  in_data, in_valid,
      output in_ready, tx_bit, tx_frame, tx_sof, underrun, frame_count
   );
endinterface

// File: rtl/sample_framer.sv
// Serializes sample words MSB first into frames of sync word, FRAME_WORDS data
// words (zero fill on input gaps) and an additive checksum.
module sample_framer #(
   parameter int                DATA_W      = 8,
   parameter int                FRAME_WORDS = 16,
   parameter int                SYNC_W      = 16,
   parameter logic [SYNC_W-1:0] SYNC_WORD   = 16'hEB90
) (
   input  logic           clk,
   input  logic           reset_n,
   sample_framer_if.slave bus
);
   localparam int SH_W = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
   localparam int BC_W = $clog2(SH_W + 1);
   localparam int WC_W = $clog2(FRAME_WORDS + 1);
   localparam logic [SH_W-1:0] SYNC_LOAD = SH_W'(SYNC_WORD) << (SH_W - SYNC_W);

   typedef enum logic [1:0] {IDLE, SYNC, DATA, CSUM} state_t;

   state_t            state_reg, state_next;
   logic [DATA_W-1:0] hold_reg, hold_next;
   logic              hold_valid_reg, hold_valid_next;
   logic [SH_W-1:0]   shreg_reg, shreg_next;
   logic [BC_W-1:0]   bit_cnt_reg, bit_cnt_next;
   logic [WC_W-1:0]   word_cnt_reg, word_cnt_next;
   logic [DATA_W-1:0] csum_reg, csum_next;
   logic              tx_bit_reg, tx_bit_next;
   logic              tx_frame_reg, tx_frame_next;
   logic              tx_sof_reg, tx_sof_next;
   logic              underrun_reg, underrun_next;
   logic [15:0]       frame_count_reg, frame_count_next;
   logic              load_word;
   logic [DATA_W-1:0] word;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg       <= IDLE;
         hold_reg        <= '0;
         hold_valid_reg  <= 1'b0;
         shreg_reg       <= '0;
         bit_cnt_reg     <= '0;
         word_cnt_reg    <= '0;
         csum_reg        <= '0;
         tx_bit_reg      <= 1'b0;
         tx_frame_reg    <= 1'b0;
         tx_sof_reg      <= 1'b0;
         underrun_reg    <= 1'b0;
         frame_count_reg <= '0;
      end else begin
         state_reg       <= state_next;
         hold_reg        <= hold_next;
         hold_valid_reg  <= hold_valid_next;
         shreg_reg       <= shreg_next;
         bit_cnt_reg     <= bit_cnt_next;
         word_cnt_reg    <= word_cnt_next;
         csum_reg        <= csum_next;
         tx_bit_reg      <= tx_bit_next;
         tx_frame_reg    <= tx_frame_next;
         tx_sof_reg      <= tx_sof_next;
         underrun_reg    <= underrun_next;
         frame_count_reg <= frame_count_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      hold_next        = hold_reg;
      hold_valid_next  = hold_valid_reg;
      shreg_next       = shreg_reg;
      bit_cnt_next     = bit_cnt_reg;
      word_cnt_next    = word_cnt_reg;
      csum_next        = csum_reg;
      tx_bit_next      = 1'b0;
      tx_frame_next    = 1'b0;
      tx_sof_next      = 1'b0;
      underrun_next    = underrun_reg;
      frame_count_next = frame_count_reg;
      load_word        = 1'b0;
      word             = '0;

      // Accept only into an empty holding register, so accept and consume never collide
      if (bus.in_valid && !hold_valid_reg) begin
         hold_next       = bus.in_data;
         hold_valid_next = 1'b1;
      end

      if (state_reg == IDLE) begin
         if (hold_valid_reg) begin
            state_next   = SYNC;
            shreg_next   = SYNC_LOAD;
            bit_cnt_next = '0;
            csum_next    = '0;
         end
      end else begin
         tx_bit_next   = shreg_reg[SH_W-1];
         tx_frame_next = 1'b1;
         tx_sof_next   = (state_reg == SYNC) && (bit_cnt_reg == '0);
         shreg_next    = shreg_reg << 1;
         bit_cnt_next  = bit_cnt_reg + BC_W'(1);
         case (state_reg)
            SYNC: begin
               if (bit_cnt_reg == BC_W'(SYNC_W - 1)) begin
                  load_word     = 1'b1;
                  word_cnt_next = WC_W'(1);
                  state_next    = DATA;
               end
            end
            DATA: begin
               if (bit_cnt_reg == BC_W'(DATA_W - 1)) begin
                  if (word_cnt_reg == WC_W'(FRAME_WORDS)) begin
                     shreg_next   = SH_W'(csum_reg) << (SH_W - DATA_W);
                     bit_cnt_next = '0;
                     state_next   = CSUM;
                  end else begin
                     load_word     = 1'b1;
                     word_cnt_next = word_cnt_reg + WC_W'(1);
                  end
               end
            end
            default: begin
               if (bit_cnt_reg == BC_W'(DATA_W - 1)) begin
                  frame_count_next = frame_count_reg + 16'd1;
                  bit_cnt_next     = '0;
                  // A waiting word chains the next frame with no gap bit
                  if (hold_valid_reg) begin
                     state_next = SYNC;
                     shreg_next = SYNC_LOAD;
                     csum_next  = '0;
                  end else begin
                     state_next = IDLE;
                  end
               end
            end
         endcase
      end

      if (load_word) begin
         bit_cnt_next = '0;
         if (hold_valid_reg) begin
            word            = hold_reg;
            hold_valid_next = 1'b0;
         end else begin
            word          = '0;
            underrun_next = 1'b1;
         end
         shreg_next = SH_W'(word) << (SH_W - DATA_W);
         csum_next  = csum_reg + word;
      end
   end

   assign bus.in_ready    = !hold_valid_reg;
   assign bus.tx_bit      = tx_bit_reg;
   assign bus.tx_frame    = tx_frame_reg;
   assign bus.tx_sof      = tx_sof_reg;
   assign bus.underrun    = underrun_reg;
   assign bus.frame_count = frame_count_reg;
endmodule

// File: tb/tb_sample_framer.sv
// Randomized self-checking bench for sample_framer: frames are rebuilt from the
// offered words (sync, words padded with zero fill, modular sum) and compared bit by bit.
module tb_sample_framer;
   localparam int          DATA_W      = 8;
   localparam int          FRAME_WORDS = 4;
   localparam int          SYNC_W      = 16;
   localparam logic [15:0] SYNC_WORD   = 16'hEB90;
   localparam int          FRAME_BITS  = SYNC_W + (FRAME_WORDS + 1) * DATA_W;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   sample_framer_if #(.DATA_W(DATA_W)) bus ();

   sample_framer #(
      .DATA_W      (DATA_W),
      .FRAME_WORDS (FRAME_WORDS),
      .SYNC_W      (SYNC_W),
      .SYNC_WORD   (SYNC_WORD)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   logic rx_q[$];
   logic exp_q[$];
   int   sof_q[$];
   bit   underrun_seen = 1'b0;
   int   underrun_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Bit monitor: collects the framed stream and marks events by cycle number
   always @(negedge clk) begin
      if (bus.tx_frame === 1'b1) rx_q.push_back(bus.tx_bit);
      if (bus.tx_sof === 1'b1) sof_q.push_back(cyc);
      if (bus.underrun === 1'b1 && !underrun_seen) begin
         underrun_seen = 1'b1;
         underrun_cyc  = cyc;
      end
   end

   function automatic void model_frame(input logic [7:0] w[$]);
      logic [15:0] s;
      logic [7:0]  sum;
      logic [7:0]  word;
      s   = SYNC_WORD;
      sum = 8'h00;
      for (int i = SYNC_W - 1; i >= 0; i--) exp_q.push_back(s[i]);
      for (int k = 0; k < FRAME_WORDS; k++) begin
         word = (k < w.size()) ? w[k] : 8'h00;
         sum  = sum + word;
         for (int b = DATA_W - 1; b >= 0; b--) exp_q.push_back(word[b]);
      end
      for (int b = DATA_W - 1; b >= 0; b--) exp_q.push_back(sum[b]);
   endfunction

   function automatic int stream_mismatches();
      int n;
      int m;
      n = (rx_q.size() > exp_q.size()) ? rx_q.size() - exp_q.size() : exp_q.size() - rx_q.size();
      m = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
      for (int i = 0; i < m; i++) if (rx_q[i] !== exp_q[i]) n++;
      return n;
   endfunction

   function automatic logic [7:0] rx_byte(input int off);
      logic [7:0] v;
      v = 8'h00;
      for (int b = 0; b < 8; b++) begin
         if (off + b < rx_q.size()) v[7-b] = rx_q[off+b];
         else v[7-b] = 1'bx;
      end
      return v;
   endfunction

   task automatic do_reset();
      bus.in_valid = 1'b0;
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      rx_q.delete();
      exp_q.delete();
      sof_q.delete();
      underrun_seen = 1'b0;
   endtask

   // Waits for in_ready, idles d cycles, then offers w for exactly one transfer
   task automatic send_word(input logic [7:0] w, input int d);
      int n;
      n = 0;
      bus.in_valid = 1'b0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.in_ready !== 1'b1 && n < 1000);
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL send_word_timeout in_ready=%b required 1", bus.in_ready);
      end else begin
         repeat (d) @(negedge clk);
         bus.in_data  = w;
         bus.in_valid = 1'b1;
         @(posedge clk);
         #1;
         bus.in_valid = 1'b0;
      end
   endtask

   task automatic wait_frames(input logic [15:0] target, input int limit, output logic [15:0] fc);
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (bus.frame_count === target) break;
      end
      fc = bus.frame_count;
   endtask

   task automatic test_reset();
      reset_n      = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hA5;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if ({bus.tx_bit, bus.tx_frame, bus.tx_sof, bus.underrun} !== 4'b0000 ||
             bus.frame_count !== 16'd0 || bus.in_ready !== 1'b1)
            begin
               errors++;
               $display("FAIL reset_hold cycle %0d got bit/frame/sof/underrun=%b%b%b%b fc=%0d ready=%b required 0000 0 1",
                        c, bus.tx_bit, bus.tx_frame, bus.tx_sof, bus.underrun, bus.frame_count, bus.in_ready);
            end
      end
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready got %b required 1", bus.in_ready);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL first_accept in_ready got %b required 0", bus.in_ready);
      end
      bus.in_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if (bus.tx_sof !== (c == 2) || bus.tx_frame !== (c == 2) || bus.tx_bit !== (c == 2)) begin
            errors++;
            $display("FAIL sof_latency cycle %0d got sof/frame/bit=%b%b%b required %b%b%b",
                     c, bus.tx_sof, bus.tx_frame, bus.tx_bit, c == 2, c == 2, c == 2);
         end
      end
      $display("test_reset done");
   endtask

   task automatic test_single_frame();
      logic [7:0]  words[$];
      logic [15:0] fc;
      int          mism;
      do_reset();
      words = '{8'h01, 8'h02, 8'h03, 8'h04};
      foreach (words[i]) send_word(words[i], 0);
      model_frame(words);
      wait_frames(16'd1, 500, fc);
      repeat (3) @(negedge clk);
      checks++;
      if (fc !== 16'd1) begin
         errors++;
         $display("FAIL single_frame_count got %0d required 1", fc);
      end
      mism = stream_mismatches();
      checks++;
      if (mism !== 0) begin
         errors++;
         $display("FAIL single_stream mismatching bits %0d (got %0d bits, required %0d)", mism, rx_q.size(), exp_q.size());
      end
      checks++;
      if (rx_q.size() !== FRAME_BITS) begin
         errors++;
         $display("FAIL single_frame_bits got %0d required %0d", rx_q.size(), FRAME_BITS);
      end
      checks++;
      if (rx_byte(48) !== 8'h0A) begin
         errors++;
         $display("FAIL single_csum got %h required 0a", rx_byte(48));
      end
      checks++;
      if (sof_q.size() !== 1) begin
         errors++;
         $display("FAIL single_sof_pulses got %0d required 1", sof_q.size());
      end
      checks++;
      if (bus.underrun !== 1'b0) begin
         errors++;
         $display("FAIL single_underrun got %b required 0", bus.underrun);
      end
      $display("test_single_frame done bits=%0d", rx_q.size());
   endtask

   task automatic test_back_to_back();
      logic [7:0]  words[$];
      logic [7:0]  grp[$];
      logic [15:0] fc;
      int          mism;
      int          gap;
      do_reset();
      words = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h80, 8'h80, 8'h80, 8'h80};
      foreach (words[i]) send_word(words[i], 0);
      grp = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
      model_frame(grp);
      grp = '{8'h80, 8'h80, 8'h80, 8'h80};
      model_frame(grp);
      wait_frames(16'd2, 1000, fc);
      repeat (3) @(negedge clk);
      checks++;
      if (fc !== 16'd2) begin
         errors++;
         $display("FAIL b2b_frame_count got %0d required 2", fc);
      end
      mism = stream_mismatches();
      checks++;
      if (mism !== 0) begin
         errors++;
         $display("FAIL b2b_stream mismatching bits %0d (got %0d bits, required %0d)", mism, rx_q.size(), exp_q.size());
      end
      checks++;
      if (rx_byte(48) !== 8'hFC || rx_byte(104) !== 8'h00) begin
         errors++;
         $display("FAIL b2b_csums got %h/%h required fc/00", rx_byte(48), rx_byte(104));
      end
      gap = (sof_q.size() >= 2) ? sof_q[1] - sof_q[0] : -1;
      checks++;
      if (gap !== FRAME_BITS) begin
         errors++;
         $display("FAIL b2b_sof_spacing got %0d required %0d", gap, FRAME_BITS);
      end
      $display("test_back_to_back done sof_spacing=%0d", gap);
   endtask

   task automatic test_underrun();
      logic [7:0]  words[$];
      logic [15:0] fc;
      int          mism;
      int          at;
      do_reset();
      words = '{8'h10, 8'h20};
      foreach (words[i]) send_word(words[i], 0);
      model_frame(words);
      wait_frames(16'd1, 500, fc);
      repeat (5) @(negedge clk);
      mism = stream_mismatches();
      checks++;
      if (mism !== 0) begin
         errors++;
         $display("FAIL underrun_stream mismatching bits %0d (got %0d bits, required %0d)", mism, rx_q.size(), exp_q.size());
      end
      checks++;
      if (rx_byte(48) !== 8'h30) begin
         errors++;
         $display("FAIL underrun_csum got %h required 30", rx_byte(48));
      end
      at = (underrun_seen && sof_q.size() > 0) ? underrun_cyc - sof_q[0] : -1;
      checks++;
      if (at !== SYNC_W + 2 * DATA_W - 1) begin
         errors++;
         $display("FAIL underrun_timing got bit %0d required %0d", at, SYNC_W + 2 * DATA_W - 1);
      end
      checks++;
      if (bus.underrun !== 1'b1 || bus.tx_frame !== 1'b0 || bus.in_ready !== 1'b1 || sof_q.size() !== 1) begin
         errors++;
         $display("FAIL underrun_idle got underrun=%b frame=%b ready=%b sofs=%0d required 1 0 1 1",
                  bus.underrun, bus.tx_frame, bus.in_ready, sof_q.size());
      end
      $display("test_underrun done underrun_bit=%0d", at);
   endtask

   task automatic test_stress();
      logic [7:0]  all_w[$];
      logic [7:0]  grp[$];
      logic [7:0]  w;
      logic [15:0] fc;
      int          d;
      int          mism;
      do_reset();
      for (int i = 0; i < 6 * FRAME_WORDS; i++) begin
         w = 8'($urandom_range(0, 255));
         d = (i % FRAME_WORDS == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, DATA_W - 3));
         send_word(w, d);
         all_w.push_back(w);
      end
      for (int f = 0; f < 6; f++) begin
         grp.delete();
         for (int k = 0; k < FRAME_WORDS; k++) grp.push_back(all_w[f*FRAME_WORDS+k]);
         model_frame(grp);
      end
      wait_frames(16'd6, 3000, fc);
      repeat (3) @(negedge clk);
      checks++;
      if (fc !== 16'd6) begin
         errors++;
         $display("FAIL stress_frame_count got %0d required 6", fc);
      end
      mism = stream_mismatches();
      checks++;
      if (mism !== 0) begin
         errors++;
         $display("FAIL stress_stream mismatching bits %0d (got %0d bits, required %0d)", mism, rx_q.size(), exp_q.size());
      end
      checks++;
      if (bus.underrun !== 1'b0) begin
         errors++;
         $display("FAIL stress_underrun got %b required 0", bus.underrun);
      end
      $display("test_stress done words=%0d bits=%0d", all_w.size(), rx_q.size());
   endtask

   task automatic test_reset_mid();
      logic [7:0]  words[$];
      logic [15:0] fc;
      int          n;
      int          mism;
      do_reset();
      send_word(8'($urandom_range(1, 255)), 0);
      send_word(8'($urandom_range(1, 255)), 0);
      n = 0;
      while ((sof_q.size() == 0 || cyc < sof_q[0] + 20) && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (bus.tx_frame !== 1'b1) begin
         errors++;
         $display("FAIL midreset_in_frame got tx_frame=%b required 1", bus.tx_frame);
      end
      reset_n = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.tx_bit, bus.tx_frame, bus.tx_sof, bus.underrun} !== 4'b0000 ||
          bus.frame_count !== 16'd0 || bus.in_ready !== 1'b1)
         begin
            errors++;
            $display("FAIL midreset_outputs got bit/frame/sof/underrun=%b%b%b%b fc=%0d ready=%b required 0000 0 1",
                     bus.tx_bit, bus.tx_frame, bus.tx_sof, bus.underrun, bus.frame_count, bus.in_ready);
         end
      rx_q.delete();
      exp_q.delete();
      sof_q.delete();
      reset_n = 1'b1;
      for (int i = 0; i < FRAME_WORDS; i++) words.push_back(8'($urandom_range(0, 255)));
      foreach (words[i]) send_word(words[i], 0);
      model_frame(words);
      wait_frames(16'd1, 500, fc);
      repeat (3) @(negedge clk);
      mism = stream_mismatches();
      checks++;
      if (mism !== 0 || fc !== 16'd1) begin
         errors++;
         $display("FAIL midreset_next_frame mismatching bits %0d fc=%0d (got %0d bits, required %0d, fc 1)",
                  mism, fc, rx_q.size(), exp_q.size());
      end
      $display("test_reset_mid done bits=%0d", rx_q.size());
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_underrun();
      test_stress();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end
endmodule
